addition_subtraction: RTL and testbench
=======================================

ADDITION_SUBTRACTION -- requirements
Module: addition_subtraction

Interface
REQ-001: The block SHALL have no parameters; the format is fixed at IEEE-754 single precision (1 sign, 8 exponent, 23 fraction bits).
REQ-002: clk  input  1  rising-edge clock.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: in_valid  input  1  operands and op are valid this cycle.
REQ-005: op  input  2  operation select: 00 = a+b, 01 = a-b, 10 and 11 = a*b.
REQ-006: a_operand  input  32  operand A, IEEE-754 single.
REQ-007: b_operand  input  32  operand B, IEEE-754 single.
REQ-008: out_valid  output  1  result and exception are valid this cycle.
REQ-009: result  output  32  IEEE-754 single result.
REQ-010: exception  output  1  invalid operand or overflow flag for the current result.

Function
REQ-011: Latency SHALL be exactly 1 cycle: inputs sampled at edge k with in_valid=1 SHALL appear on result/exception with out_valid=1 after edge k.
REQ-012: There is no handshake or backpressure; a new operation SHALL be accepted every cycle.
REQ-013: When in_valid=0 at an edge, out_valid SHALL be 0 after that edge, and result/exception SHALL hold their previous values.
REQ-014: Subtraction SHALL be computed as a + (b with its sign bit inverted).
REQ-015: Add/sub steps: order operands by magnitude; right-shift the smaller significand (hidden 1 restored) by the exponent difference; add or subtract significands; normalise with a leading-one shift and exponent adjust.
REQ-016: Shifts of 24 or more SHALL reduce the smaller operand's contribution to zero.
REQ-017: Add/sub result sign SHALL be the sign of the larger-magnitude operand.
REQ-018: Exact cancellation (equal magnitudes, opposite effective signs) SHALL produce +0 (0x00000000).
REQ-019: Multiply: sign = sA XOR sB; exponent = eA + eB - 127; 24x24-bit significand product normalised by at most one left position; exponent +1 when product bit 47 is set.
REQ-020: Rounding SHALL be truncation (round toward zero) for every operation; discarded bits are dropped.
REQ-021: Zero/denormal inputs: an operand with exponent field 0 SHALL be treated as signed zero (fraction ignored).
REQ-022: Adding zero SHALL return the other operand unchanged.
REQ-023: Multiplying by zero SHALL return zero with sign sA XOR sB.
REQ-024: Invalid operands: if either operand has exponent field 255 (Inf/NaN), exception SHALL be 1 and result SHALL be 0x7FC00000.
REQ-025: Overflow: a normalised exponent above 254 SHALL give exception=1 and result = signed infinity (sign|0x7F800000).
REQ-026: Underflow: a normalised exponent below 1 SHALL give result = signed zero with exception=0.
REQ-027: exception SHALL be 0 for all other results.

Reset
REQ-028: While reset is high at a clock edge, out_valid, result and exception SHALL be cleared to 0 regardless of in_valid.
REQ-029: An operation sampled in the same cycle as reset SHALL be discarded.
REQ-030: The first valid output after reset deasserts SHALL be the operation sampled at the first edge with reset=0 and in_valid=1.

Verification
REQ-031: Add: op=00, A=0x3F800000, B=0x40000000 -> result 0x40400000 (3.0), exception 0, out_valid 1 cycle later.
REQ-032: Sub: op=01, A=0x3F800000, B=0x40000000 -> result 0xBF800000 (-1.0).
REQ-033: Cancellation: op=01, A=B=0x40400000 -> result 0x00000000.
REQ-034: Multiply: op=10, A=0x3FC00000, B=0x40000000 -> result 0x40400000; op=10, A=0xBF800000, B=0x00000000 -> result 0x80000000.
REQ-035: Exceptions:
- op=00, A=0x7F800000, B=0x3F800000 -> result 0x7FC00000, exception 1.
- op=10, A=0x7F000000, B=0x40000000 -> result 0x7F800000, exception 1.
REQ-036: Streaming and reset:
- Back-to-back valid operations over 3 cycles -> 3 consecutive correct results.
- Reset asserted with in_valid=1 -> out_valid 0 and result 0 next cycle.

Source files
------------

// File: rtl/addition_subtraction.sv
// Single-precision float add/subtract/multiply with one registered output stage.
// Truncating rounding; zero/denormal inputs are treated as signed zero.
module addition_subtraction (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  op,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        exception
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q, result_d;
  logic        exception_q, exception_d;

  logic        sign_a, sign_b, sign_b_eff;
  logic [7:0]  exp_a, exp_b;
  logic        zero_a, zero_b, invalid;
  logic        is_mul;

  assign sign_a     = a_operand[31];
  assign sign_b     = b_operand[31];
  assign sign_b_eff = sign_b ^ (op == 2'b01);
  assign exp_a      = a_operand[30:23];
  assign exp_b      = b_operand[30:23];
  assign zero_a     = (exp_a == 8'd0);
  assign zero_b     = (exp_b == 8'd0);
  assign invalid    = (exp_a == 8'hFF) || (exp_b == 8'hFF);
  assign is_mul     = op[1];

  // Add/sub datapath
  logic        a_larger, sign_l, sign_s;
  logic [7:0]  exp_l, exp_s, exp_diff;
  logic [23:0] man_l, man_s, man_s_shift, man_diff, man_norm;
  logic [24:0] man_sum;
  logic [4:0]  lead_pos, lz;
  logic signed [9:0] exp_n;
  logic [31:0] addsub_result;
  logic        addsub_exc;

  always_comb begin
    a_larger      = (a_operand[30:0] >= b_operand[30:0]);
    sign_l        = a_larger ? sign_a : sign_b_eff;
    sign_s        = a_larger ? sign_b_eff : sign_a;
    exp_l         = a_larger ? exp_a : exp_b;
    exp_s         = a_larger ? exp_b : exp_a;
    man_l         = a_larger ? {1'b1, a_operand[22:0]} : {1'b1, b_operand[22:0]};
    man_s         = a_larger ? {1'b1, b_operand[22:0]} : {1'b1, a_operand[22:0]};
    exp_diff      = exp_l - exp_s;
    man_s_shift   = (exp_diff >= 8'd24) ? 24'd0 : (man_s >> exp_diff);
    man_sum       = {1'b0, man_l} + {1'b0, man_s_shift};
    man_diff      = man_l - man_s_shift;
    lead_pos      = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (man_diff[i]) lead_pos = 5'(i);
    end
    lz            = 5'd23 - lead_pos;
    man_norm      = man_diff << lz;
    exp_n         = 10'sd0;
    addsub_result = 32'd0;
    addsub_exc    = 1'b0;

    if (zero_b) begin
      addsub_result = a_operand;
    end else if (zero_a) begin
      addsub_result = {sign_b_eff, b_operand[30:0]};
    end else if (sign_l == sign_s) begin
      exp_n = $signed({2'b00, exp_l}) + $signed({9'd0, man_sum[24]});
      if (exp_n > 10'sd254) begin
        addsub_result = {sign_l, 31'h7F800000};
        addsub_exc    = 1'b1;
      end else if (man_sum[24]) begin
        addsub_result = {sign_l, exp_n[7:0], man_sum[23:1]};
      end else begin
        addsub_result = {sign_l, exp_n[7:0], man_sum[22:0]};
      end
    end else if (man_diff == 24'd0) begin
      addsub_result = 32'd0;
    end else begin
      exp_n = $signed({2'b00, exp_l}) - $signed({5'd0, lz});
      if (exp_n < 10'sd1) begin
        addsub_result = {sign_l, 31'd0};
      end else begin
        addsub_result = {sign_l, exp_n[7:0], man_norm[22:0]};
      end
    end
  end

  // Multiply datapath
  logic [47:0] product;
  logic        sign_m;
  logic signed [9:0] exp_m;
  logic [31:0] mul_result;
  logic        mul_exc;

  always_comb begin
    sign_m     = sign_a ^ sign_b;
    product    = 48'({1'b1, a_operand[22:0]}) * 48'({1'b1, b_operand[22:0]});
    exp_m      = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127
                 + $signed({9'd0, product[47]});
    mul_result = 32'd0;
    mul_exc    = 1'b0;
    if (zero_a || zero_b) begin
      mul_result = {sign_m, 31'd0};
    end else if (exp_m > 10'sd254) begin
      mul_result = {sign_m, 31'h7F800000};
      mul_exc    = 1'b1;
    end else if (exp_m < 10'sd1) begin
      mul_result = {sign_m, 31'd0};
    end else if (product[47]) begin
      mul_result = {sign_m, exp_m[7:0], product[46:24]};
    end else begin
      mul_result = {sign_m, exp_m[7:0], product[45:23]};
    end
  end

  // Idle cycles keep the last result visible with out_valid low
  always_comb begin
    out_valid_d = in_valid;
    result_d    = result_q;
    exception_d = exception_q;
    if (in_valid) begin
      if (invalid) begin
        result_d    = 32'h7FC00000;
        exception_d = 1'b1;
      end else if (is_mul) begin
        result_d    = mul_result;
        exception_d = mul_exc;
      end else begin
        result_d    = addsub_result;
        exception_d = addsub_exc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'd0;
      exception_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      exception_q <= exception_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign exception = exception_q;

endmodule

// File: tb/tb_addition_subtraction.sv
// Directed bench for addition_subtraction: hand-computed vectors, one cycle latency.
module tb_addition_subtraction;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] a_operand;
  logic [31:0] b_operand;
  logic        out_valid;
  logic [31:0] result;
  logic        exception;

  int checks = 0;
  int errors = 0;

  addition_subtraction dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .op        (op),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .out_valid (out_valid),
    .result    (result),
    .exception (exception)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then check the registered outputs 1 time unit after the edge
  task automatic step(input logic rst, input logic v, input logic [1:0] o,
                      input logic [31:0] a, input logic [31:0] b, input string tag,
                      input logic ev, input logic [31:0] er, input logic ee);
    reset     = rst;
    in_valid  = v;
    op        = o;
    a_operand = a;
    b_operand = b;
    @(posedge clk);
    #1;
    checks++;
    assert (out_valid === ev) else begin
      errors++;
      $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, ev);
    end
    checks++;
    assert (result === er) else begin
      errors++;
      $error("FAIL %s result: got %h expected %h", tag, result, er);
    end
    checks++;
    assert (exception === ee) else begin
      errors++;
      $error("FAIL %s exception: got %b expected %b", tag, exception, ee);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 2'b00; a_operand = 32'd0; b_operand = 32'd0;
    step(1'b1, 1'b1, 2'b00, 32'h3F800000, 32'h40000000, "reset_in", 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 2'b10, 32'h7F800000, 32'h40000000, "reset_in2", 1'b0, 32'h0, 1'b0);

    step(1'b0, 1'b1, 2'b00, 32'h3F800000, 32'h40000000, "add_1_2", 1'b1, 32'h40400000, 1'b0);
    step(1'b0, 1'b1, 2'b01, 32'h3F800000, 32'h40000000, "sub_1_2", 1'b1, 32'hBF800000, 1'b0);
    step(1'b0, 1'b1, 2'b01, 32'h40400000, 32'h40400000, "cancel", 1'b1, 32'h00000000, 1'b0);
    step(1'b0, 1'b1, 2'b10, 32'h3FC00000, 32'h40000000, "mul_1p5_2", 1'b1, 32'h40400000, 1'b0);
    step(1'b0, 1'b0, 2'b00, 32'h3F800000, 32'h3F800000, "hold", 1'b0, 32'h40400000, 1'b0);
    step(1'b0, 1'b1, 2'b10, 32'hBF800000, 32'h00000000, "mul_neg_zero", 1'b1, 32'h80000000, 1'b0);
    step(1'b0, 1'b1, 2'b00, 32'h7F800000, 32'h3F800000, "add_inf", 1'b1, 32'h7FC00000, 1'b1);
    step(1'b0, 1'b1, 2'b10, 32'h7F000000, 32'h40000000, "mul_ovf", 1'b1, 32'h7F800000, 1'b1);
    step(1'b0, 1'b1, 2'b10, 32'h3FC00000, 32'h3FC00000, "mul_carry", 1'b1, 32'h40100000, 1'b0);
    step(1'b0, 1'b1, 2'b11, 32'h40000000, 32'h40000000, "mul_op11", 1'b1, 32'h40800000, 1'b0);
    step(1'b0, 1'b1, 2'b00, 32'h3F800000, 32'h00000000, "add_zero_b", 1'b1, 32'h3F800000, 1'b0);
    step(1'b0, 1'b1, 2'b01, 32'h00000000, 32'h3F800000, "sub_zero_a", 1'b1, 32'hBF800000, 1'b0);
    step(1'b0, 1'b1, 2'b00, 32'h00000001, 32'h40000000, "denorm_in", 1'b1, 32'h40000000, 1'b0);
    step(1'b0, 1'b1, 2'b00, 32'h3F800000, 32'h33800000, "shift24", 1'b1, 32'h3F800000, 1'b0);
    step(1'b0, 1'b1, 2'b00, 32'h3F800000, 32'h34000000, "shift23", 1'b1, 32'h3F800001, 1'b0);
    step(1'b0, 1'b1, 2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, "add_ovf", 1'b1, 32'h7F800000, 1'b1);
    step(1'b0, 1'b1, 2'b01, 32'h00C00000, 32'h00800000, "sub_unf", 1'b1, 32'h00000000, 1'b0);
    step(1'b0, 1'b1, 2'b10, 32'h80800000, 32'h00800000, "mul_unf", 1'b1, 32'h80000000, 1'b0);
    step(1'b0, 1'b1, 2'b10, 32'h3F800000, 32'h7FC00000, "mul_nan", 1'b1, 32'h7FC00000, 1'b1);
    step(1'b0, 1'b1, 2'b01, 32'hC0000000, 32'hBF800000, "sub_negs", 1'b1, 32'hBF800000, 1'b0);

    step(1'b1, 1'b1, 2'b00, 32'h3F800000, 32'h3F800000, "reset_mid", 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 2'b00, 32'h40000000, 32'h40000000, "first_after", 1'b1, 32'h40800000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
